btb_update_ctrl: RTL

//  Sequences every write into the branch target buffer (BTB) write port.
//  - Queues EX-stage branch/jump updates in a small FIFO.
//  - Runs a one-entry-per-cycle invalidation sweep after reset and on flush_req (e.g. FENCE.I).
//  - Arbitrates the single BTB write port: sweep writes always win; queued updates drain when idle.

---
 rtl/btb_update_ctrl_if.sv | 29 ++
 rtl/btb_update_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/btb_update_ctrl_if.sv
// rtl/btb_update_ctrl_if.sv - update request and BTB write-port bundle for btb_update_ctrl
interface btb_update_ctrl_if #(
  parameter int SIZE  = 1024,
  parameter int TAG_W = 20
);
  localparam int IDX_W = $clog2(SIZE);

  logic             flush_req;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic [31:0]      upd_target;
  logic             fifo_full;
  logic             busy;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_valid;
  logic [TAG_W-1:0] wr_tag;
  logic [31:0]      wr_target;

  modport master (
    output flush_req, upd_valid, upd_pc, upd_target,
    input  fifo_full, busy, wr_en, wr_idx, wr_valid, wr_tag, wr_target
  );

  modport slave (
    input  flush_req, upd_valid, upd_pc, upd_target,
    output fifo_full, busy, wr_en, wr_idx, wr_valid, wr_tag, wr_target
  );
endinterface

// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - BTB write-port sequencer: invalidation sweep plus queued EX updates
// Optional BTB_STATS_EN adds upd_cnt/drop_cnt counters.
module btb_update_ctrl #(
  parameter int SIZE       = 1024,
  parameter int IDX_W      = $clog2(SIZE),
  parameter int TAG_W      = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  btb_update_ctrl_if.slave   bus
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]        upd_cnt,
  output logic [31:0]        drop_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {SWEEP, RUN} state_t;

  state_t           state;
  logic [IDX_W-1:0] sweep_idx;
  logic             busy_q;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [TAG_W-1:0] q_tag    [FIFO_DEPTH];
  logic [31:0]      q_target [FIFO_DEPTH];

  logic full;
  logic empty;
  logic pop;
  logic push;
  logic drop;
  logic unused_pc_hi;

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);

  // A flush discards the queue, so neither a pop nor a push may happen alongside it.
  assign pop  = (state == RUN) && !empty && !bus.flush_req;
  assign push = bus.upd_valid && !bus.flush_req && (!full || pop);
  assign drop = bus.upd_valid && !bus.flush_req && full && !pop;

  assign unused_pc_hi = ^bus.upd_pc[31:TAG_W];

  assign bus.fifo_full = full;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= SWEEP;
      sweep_idx     <= '0;
      busy_q        <= 1'b1;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      bus.wr_en     <= 1'b0;
      bus.wr_valid  <= 1'b0;
      bus.wr_idx    <= '0;
      bus.wr_tag    <= '0;
      bus.wr_target <= '0;
    end else if (bus.flush_req) begin
      // Index 0 is written right away; the sweep resumes from index 1.
      state         <= SWEEP;
      sweep_idx     <= IDX_W'(1);
      busy_q        <= 1'b1;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      bus.wr_en     <= 1'b1;
      bus.wr_valid  <= 1'b0;
      bus.wr_idx    <= '0;
      bus.wr_tag    <= '0;
      bus.wr_target <= '0;
    end else begin
      case (state)
        SWEEP: begin
          bus.wr_en     <= 1'b1;
          bus.wr_valid  <= 1'b0;
          bus.wr_idx    <= sweep_idx;
          bus.wr_tag    <= '0;
          bus.wr_target <= '0;
          busy_q        <= 1'b1;
          sweep_idx     <= sweep_idx + IDX_W'(1);
          if (sweep_idx == IDX_W'(SIZE - 1)) begin
            state <= RUN;
          end
        end
        RUN: begin
          busy_q <= 1'b0;
          if (pop) begin
            bus.wr_en     <= 1'b1;
            bus.wr_valid  <= 1'b1;
            bus.wr_idx    <= q_tag[rd_ptr][IDX_W-1:0];
            bus.wr_tag    <= q_tag[rd_ptr];
            bus.wr_target <= q_target[rd_ptr];
          end else begin
            bus.wr_en     <= 1'b0;
            bus.wr_valid  <= 1'b0;
            bus.wr_idx    <= '0;
            bus.wr_tag    <= '0;
            bus.wr_target <= '0;
          end
        end
        default: begin
          state <= SWEEP;
        end
      endcase

      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage needs no reset: count and pointers define which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      q_tag[wr_ptr]    <= bus.upd_pc[TAG_W-1:0];
      q_target[wr_ptr] <= bus.upd_target;
    end
  end

`ifdef BTB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (pop) begin
        upd_cnt <= upd_cnt + 32'd1;
      end
      if (drop) begin
        drop_cnt <= drop_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
